apb_pstwo_ctrl: RTL

Hardware poll engine for the PlayStation-2 gamepad on the APB peripheral bus. It replaces software bit-banging of CS/CLK/DO/DI with a sequenced 9-byte poll transaction (0x01, 0x42, then seven 0x00). Received controller bytes land in readable registers, so game code reads buttons and sticks with two APB reads. It sits at BASE_ADDR 0x40006000, alongside the existing APB peripherals.

---
 rtl/apb_pstwo_pkg.sv | 43 ++++
 rtl/pstwo_byte_shifter.sv | 34 +++
 rtl/apb_pstwo_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pstwo_pkg.sv
// Shared definitions for the APB PS2 gamepad poll engine: register offsets,
// protocol bytes, STATUS bit positions and the sequencer state encoding.
package apb_pstwo_pkg;

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_STATUS = 12'h004;
  localparam logic [11:0] ADDR_DATA0  = 12'h008;
  localparam logic [11:0] ADDR_DATA1  = 12'h00C;
  localparam logic [11:0] ADDR_PERIOD = 12'h010;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] ID_ACK    = 8'h5A;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;

  localparam logic [23:0] PERIOD_RST = 24'h0C3500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_GAP,
    ST_CS_HOLD,
    ST_FINISH
  } state_t;

  // Command byte sent in each of the 9 transaction slots.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return CMD_START;
      4'd1:    return CMD_POLL;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pstwo_byte_shifter.sv
// Full-duplex 8-bit LSB-first shifter: DO is registered so it only moves on
// load/shift strobes; rx bits enter at the MSB and walk down.
module pstwo_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic       sample,
  input  logic [7:0] tx_byte,
  input  logic       di,
  output logic       do_bit,
  output logic [7:0] rx_byte
);

  logic [7:0] tx_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr   <= 8'hFF;
      do_bit  <= 1'b1;
      rx_byte <= 8'hFF;
    end else begin
      if (load) begin
        do_bit <= tx_byte[0];
        tx_sr  <= {1'b1, tx_byte[7:1]};
      end else if (shift) begin
        do_bit <= tx_sr[0];
        tx_sr  <= {1'b1, tx_sr[7:1]};
      end
      if (sample) rx_byte <= {di, rx_byte[7:1]};
    end
  end

endmodule

// File: rtl/apb_pstwo_ctrl.sv
// APB PS2 gamepad poll engine: sequences a 9-byte poll and publishes bytes 1..8.
// Optional auto-poll timer, AUTO bit and PERIOD register under PSTWO_AUTO_POLL_EN.
module apb_pstwo_ctrl
  import apb_pstwo_pkg::*;
#(
  parameter int CLK_DIV  = 100,
  parameter int BYTE_GAP = 200
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PS2_CS,
  output logic        PS2_CLK,
  output logic        PS2_DO,
  input  logic        PS2_DI,
  output state_t      dbg_state
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic [63:0] shadow;
  logic [31:0] data0, data1;
  logic        done, err, busy;
  logic        di_meta, di_sync;
  logic        load, shift, sample, byte_end;
  logic        tick, ctrl_auto, start_req;
  logic [23:0] period_rd;
  logic [7:0]  rx_byte;
  logic        do_bit;

  wire        wr   = PSEL & ~PENABLE & PWRITE;
  wire [11:0] addr = PADDR[11:0];

  logic unused_bits;
  assign unused_bits = ^{PADDR[15:12], PWDATA[31:3]};

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign dbg_state = state;
  assign busy      = (state != ST_IDLE);
  assign start_req = (wr && addr == ADDR_CTRL && PWDATA[CTRL_START]) || tick;

  assign PS2_CS  = (state == ST_IDLE) || (state == ST_FINISH);
  assign PS2_CLK = (state != ST_BIT_LO);
  assign PS2_DO  = do_bit;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      di_meta <= 1'b1;
      di_sync <= 1'b1;
    end else begin
      di_meta <= PS2_DI;
      di_sync <= di_meta;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    sample     = 1'b0;
    byte_end   = 1'b0;
    unique case (state)
      ST_IDLE:     if (start_req) state_next = ST_CS_SETUP;
      ST_CS_SETUP: if (cnt == DIV_LAST) begin state_next = ST_BIT_LO; load = 1'b1; end
      ST_BIT_LO:   if (cnt == DIV_LAST) state_next = ST_BIT_HI;
      ST_BIT_HI: begin
        sample = (cnt == 16'd0);
        if (cnt == DIV_LAST) begin
          if (bit_idx == 3'd7) begin
            byte_end   = 1'b1;
            state_next = (byte_idx == 4'd8) ? ST_CS_HOLD : ST_GAP;
          end else begin
            state_next = ST_BIT_LO;
            shift      = 1'b1;
          end
        end
      end
      ST_GAP:      if (cnt == GAP_LAST) begin state_next = ST_BIT_LO; load = 1'b1; end
      ST_CS_HOLD:  if (cnt == DIV_LAST) state_next = ST_FINISH;
      ST_FINISH:   state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      cnt      <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      shadow   <= '1;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state || state == ST_IDLE) ? 16'd0 : cnt + 16'd1;
      if (state == ST_BIT_HI && cnt == DIV_LAST) bit_idx <= bit_idx + 3'd1;
      if (state == ST_IDLE) byte_idx <= 4'd0;
      else if (byte_end) byte_idx <= byte_idx + 4'd1;
      // Byte 0 is the controller's idle response and is dropped.
      if (byte_end && byte_idx != 4'd0) shadow <= {rx_byte, shadow[63:8]};
    end
  end

  pstwo_byte_shifter u_shifter (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .load    (load),
    .shift   (shift),
    .sample  (sample),
    .tx_byte (cmd_byte(byte_idx)),
    .di      (di_sync),
    .do_bit  (do_bit),
    .rx_byte (rx_byte)
  );

  // Hardware set outranks a same-cycle W1C, so a completing poll is never lost.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      done  <= 1'b0;
      err   <= 1'b0;
      data0 <= 32'hFFFF_FFFF;
      data1 <= 32'hFFFF_FFFF;
    end else begin
      if (state == ST_FINISH) done <= 1'b1;
      else if (wr && addr == ADDR_STATUS && PWDATA[STAT_DONE]) done <= 1'b0;
      if (state == ST_FINISH && shadow[15:8] != ID_ACK) err <= 1'b1;
      else if (wr && addr == ADDR_STATUS && PWDATA[STAT_ERR]) err <= 1'b0;
      if (state == ST_FINISH && shadow[15:8] == ID_ACK) begin
        data0 <= shadow[31:0];
        data1 <= shadow[63:32];
      end
    end
  end

`ifdef PSTWO_AUTO_POLL_EN
  logic        auto_q;
  logic [23:0] period_q, timer;

  // Tick is registered, so a poll starts PERIOD+2 idle cycles after FINISH.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      auto_q   <= 1'b0;
      period_q <= PERIOD_RST;
      timer    <= 24'd0;
      tick     <= 1'b0;
    end else begin
      if (wr && addr == ADDR_CTRL)   auto_q   <= PWDATA[CTRL_AUTO];
      if (wr && addr == ADDR_PERIOD) period_q <= PWDATA[23:0];
      if (state == ST_FINISH) timer <= (period_q == 24'd0) ? 24'd1 : period_q;
      else if (state == ST_IDLE && auto_q && timer != 24'd0) timer <= timer - 24'd1;
      tick <= (state == ST_IDLE) && auto_q && (timer == 24'd0);
    end
  end

  assign ctrl_auto = auto_q;
  assign period_rd = period_q;
`else
  assign tick      = 1'b0;
  assign ctrl_auto = 1'b0;
  assign period_rd = 24'd0;
`endif

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      case (addr)
        ADDR_CTRL:   PRDATA = {30'd0, ctrl_auto, 1'b0};
        ADDR_STATUS: PRDATA = {29'd0, err, done, busy};
        ADDR_DATA0:  PRDATA = data0;
        ADDR_DATA1:  PRDATA = data1;
        ADDR_PERIOD: PRDATA = {8'd0, period_rd};
        default:     PRDATA = 32'd0;
      endcase
    end
  end

endmodule
